// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle N-bit subtractor, D = A - B - Bin with
// borrow-out Bout, processing W bits per clock, least-significant chunk first.
// Handshake: start is accepted in IDLE or DONE, busy is high while chunks are
// being processed, and done pulses for one cycle when D/Bout become valid.
// D and Bout hold their values until the next accepted start.
// Optional build macro SERIAL_SUBTRACTOR_FLAGS_EN adds the registered flags
// V (signed overflow of A - B - Bin) and Z (D == 0).
module serial_subtractor #(
   parameter int N = 8,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] D,
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
   output logic         V,
   output logic         Z,
`endif
   output logic         Bout
);

   // Number of chunks and a counter wide enough to index them (at least 1 bit).
   localparam int NCH   = (W >= 1) ? (N / W) : 1;
   localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

   // Reject illegal parameter combinations at elaboration.
   generate
      if ((N < 1) || (W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
         $error("serial_subtractor: requires N >= 1, 1 <= W <= N and N %% W == 0");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [N-1:0]     a_q;
   logic [N-1:0]     b_q;
   logic             borrow_q;
   logic [CNT_W-1:0] cnt_q;
   logic [N-1:0]     d_q;
   logic             bout_q;
   logic             busy_q;
   logic             done_q;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
   logic             v_q;
   logic             z_q;
`endif

   // Latched operands split into chunks so the active chunk is a plain mux.
   logic [W-1:0] a_chunk [NCH];
   logic [W-1:0] b_chunk [NCH];

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chunk
         assign a_chunk[gi] = a_q[gi*W +: W];
         assign b_chunk[gi] = b_q[gi*W +: W];
      end
   endgenerate

   logic [W-1:0] a_cur;
   logic [W-1:0] b_cur;
   logic [W:0]   diff_d;
   logic [N-1:0] d_d;
   logic         last_chunk;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
   logic         v_d;
   logic         z_d;
`endif

   // Datapath for the current chunk: W+1-bit subtract; the top bit is the borrow.
   always_comb begin
      a_cur      = a_chunk[cnt_q];
      b_cur      = b_chunk[cnt_q];
      diff_d     = {1'b0, a_cur} - {1'b0, b_cur} - {{W{1'b0}}, borrow_q};
      d_d        = d_q;
      d_d[int'(cnt_q)*W +: W] = diff_d[W-1:0];
      last_chunk = (cnt_q == LAST_CNT);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      // Operand signs differ and result sign differs from the minuend: overflow.
      // This also holds with Bin, since equal-sign operands cannot overflow
      // even after subtracting the extra one.
      v_d        = (a_q[N-1] != b_q[N-1]) && (d_d[N-1] != a_q[N-1]);
      z_d        = (d_d == '0);
`endif
   end

   // Control FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
         v_q      <= 1'b0;
         z_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q      <= A;
                  b_q      <= B;
                  borrow_q <= Bin;
                  cnt_q    <= '0;
                  d_q      <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_RUN;
               end else begin
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               d_q      <= d_d;
               borrow_q <= diff_d[W];
               cnt_q    <= cnt_q + 1'b1;
               if (last_chunk) begin
                  bout_q  <= diff_d[W];
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
                  v_q     <= v_d;
                  z_q     <= z_d;
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign D    = d_q;
   assign Bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
   assign V    = v_q;
   assign Z    = z_q;
`endif

endmodule
